// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
// Module  : light_pkg
// Purpose : Constants, FSM state type and saturating arithmetic helpers
//           shared by the PWM light stage and the duty fader.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package light_pkg;

  // PWM period in clk cycles; also the largest legal duty value.
  localparam int PERIOD     = 50_000;
  localparam int LEVEL_STEP = 5_000;
  localparam int RAMP_STEP  = 50;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    RAMP_UP   = 3'd1,
    RAMP_DOWN = 3'd2,
    BR_UP     = 3'd3,
    BR_DOWN   = 3'd4
  } fader_state_t;

  // min(a + b, hi), carried in 17 bits so the sum cannot wrap before the compare.
  function automatic logic [15:0] sat_add(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] hi);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, hi}) return hi;
    return sum[15:0];
  endfunction

  // max(a - b, lo), decided before subtracting so nothing goes negative.
  function automatic logic [15:0] sat_sub(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] lo);
    logic [16:0] floor_sum;
    floor_sum = {1'b0, b} + {1'b0, lo};
    if ({1'b0, a} < floor_sum) return lo;
    return a - b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/duty_fader_if.sv
`default_nettype none
// ============================================================================
// Module  : duty_fader_if
// Purpose : Groups the fader's user inputs and PWM-facing outputs.
// Ports   : btn_up, btn_down, breathe  - user controls (raw, asynchronous)
//           duty[15:0]                 - duty word to the PWM stage
//           at_target                  - duty settled on target, not breathing
//           period_tick                - one-cycle pulse at each period end
//           master modport: control side; slave modport: the fader itself
// Revision: 1.0 - initial release
// ============================================================================
interface duty_fader_if;
  logic        btn_up;
  logic        btn_down;
  logic        breathe;
  logic [15:0] duty;
  logic        at_target;
  logic        period_tick;

  modport master (
    output btn_up, btn_down, breathe,
    input  duty, at_target, period_tick
  );

  modport slave (
    input  btn_up, btn_down, breathe,
    output duty, at_target, period_tick
  );
endinterface
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// Module  : btn_edge
// Purpose : Two-flop synchronizer for an asynchronous input, optionally
//           followed by a rising-edge detector producing one pulse per press.
// Ports   : clk, rst_n (async, active-low)
//           din  - raw asynchronous input
//           dout - rising-edge pulse (EDGE_DETECT=1) or synchronized level
// Revision: 1.0 - initial release
// ============================================================================
module btn_edge #(
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], din};
  end

  generate
    if (EDGE_DETECT) begin : g_edge
      logic prev;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= sync[1];
      end

      // High only in the first cycle the synchronized level is seen high,
      // so a held button yields a single pulse.
      assign dout = sync[1] & ~prev;
    end else begin : g_level
      assign dout = sync[1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/duty_fader.sv
`default_nettype none
// ============================================================================
// Module  : duty_fader
// Purpose : Brightness controller. Keeps a button-selected target level and
//           ramps the PWM duty word toward it once per PWM period, or sweeps
//           between 0 and the target in breathe mode.
// Ports   : clk          - system clock
//           rst_n        - asynchronous active-low reset
//           bus (slave)  - btn_up/btn_down/breathe in; duty/at_target/
//                          period_tick out
// Revision: 1.0 - initial release
// ============================================================================
module duty_fader #(
  parameter int PERIOD     = light_pkg::PERIOD,
  parameter int LEVEL_STEP = light_pkg::LEVEL_STEP,
  parameter int RAMP_STEP  = light_pkg::RAMP_STEP
) (
  input  logic         clk,
  input  logic         rst_n,
  duty_fader_if.slave  bus
);
  import light_pkg::*;

  localparam logic [15:0] PERIOD_W = 16'(PERIOD);
  localparam logic [15:0] PCNT_MAX = 16'(PERIOD - 1);
  localparam logic [15:0] LEVEL_W  = 16'(LEVEL_STEP);
  localparam logic [15:0] RAMP_W   = 16'(RAMP_STEP);

  logic [15:0]  pcnt;
  logic         tick;
  logic         up_pulse;
  logic         down_pulse;
  logic         breathe_s;
  logic [15:0]  target;
  logic [15:0]  duty;
  logic [15:0]  duty_nxt;
  logic [15:0]  ramp_duty;
  fader_state_t state;
  fader_state_t state_nxt;
  fader_state_t ramp_state;

  btn_edge #(.EDGE_DETECT(1'b1)) u_up (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.btn_up),
    .dout (up_pulse)
  );

  btn_edge #(.EDGE_DETECT(1'b1)) u_down (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.btn_down),
    .dout (down_pulse)
  );

  btn_edge #(.EDGE_DETECT(1'b0)) u_breathe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.breathe),
    .dout (breathe_s)
  );

  // Period counter, aligned with the downstream PWM counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pcnt <= '0;
    else if (pcnt == PCNT_MAX) pcnt <= '0;
    else                    pcnt <= pcnt + 16'd1;
  end

  assign tick = (pcnt == PCNT_MAX);

  // Target level; simultaneous up and down presses cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
    end else if (up_pulse && !down_pulse) begin
      target <= sat_add(target, LEVEL_W, PERIOD_W);
    end else if (down_pulse && !up_pulse) begin
      target <= sat_sub(target, LEVEL_W, 16'd0);
    end
  end

  // One ramp step toward target. Shared by HOLD, both ramp states and the
  // exit from breathe, which makes a mid-ramp reversal a direct switch.
  always_comb begin
    ramp_duty  = duty;
    ramp_state = HOLD;
    if (target > duty) begin
      ramp_duty  = sat_add(duty, RAMP_W, target);
      ramp_state = (ramp_duty == target) ? HOLD : RAMP_UP;
    end else if (target < duty) begin
      ramp_duty  = sat_sub(duty, RAMP_W, target);
      ramp_state = (ramp_duty == target) ? HOLD : RAMP_DOWN;
    end
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    case (state)
      HOLD: begin
        if (breathe_s) begin
          state_nxt = BR_DOWN;
        end else begin
          state_nxt = ramp_state;
          duty_nxt  = ramp_duty;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        state_nxt = ramp_state;
        duty_nxt  = ramp_duty;
      end
      BR_DOWN: begin
        if (!breathe_s) begin
          state_nxt = ramp_state;
          duty_nxt  = ramp_duty;
        end else begin
          duty_nxt  = sat_sub(duty, RAMP_W, 16'd0);
          state_nxt = (duty_nxt == 16'd0) ? BR_UP : BR_DOWN;
        end
      end
      BR_UP: begin
        if (!breathe_s) begin
          state_nxt = ramp_state;
          duty_nxt  = ramp_duty;
        end else begin
          // With target == 0 this lands on target at once, so the FSM
          // alternates BR_UP/BR_DOWN while duty stays at 0.
          duty_nxt  = sat_add(duty, RAMP_W, target);
          state_nxt = (duty_nxt == target) ? BR_DOWN : BR_UP;
        end
      end
      default: begin
        state_nxt = HOLD;
        duty_nxt  = duty;
      end
    endcase
  end

  // Duty and state advance only on the edge ending the tick cycle, which is
  // also where the PWM counter wraps: each PWM period sees one duty value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD;
      duty  <= '0;
    end else if (tick) begin
      state <= state_nxt;
      duty  <= duty_nxt;
    end
  end

  assign bus.duty        = duty;
  assign bus.period_tick = tick;
  assign bus.at_target   = (state == HOLD) && (duty == target);

endmodule
`default_nettype wire
